ex_mem_pipe_stage: RTL and testbench
====================================

EX_MEM_PIPE_STAGE -- requirements
Module: ex_mem_pipe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of ALU result, store data and PC+4 fields.
REQ-002 SHALL have parameter RDW, default 5, width of destination register address.
REQ-003 SHALL have parameter WBSELW, default 2, width of writeback-select field.
REQ-004 SHALL have parameter CNTW, default 16, width of stall counter.
REQ-005 Ports: clk  in  1  rising-edge clock.
REQ-006 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Ports: flush  in  1  squash stage contents (branch/exception).
REQ-008 Ports: ex_valid  in  1  EX offers a bundle; ex_ready  out  1  stage accepts a bundle.
REQ-009 Ports: ex_alu_res, ex_rs2o, ex_pcp4  in  XLEN each; ex_rdaddr  in  RDW; ex_wbsel  in  WBSELW; ex_memwr, ex_regwr  in  1 each.
REQ-010 Ports: mem_valid  out  1  bundle present; mem_ready  in  1  MEM consumes bundle.
REQ-011 Ports: mem_alu_res, mem_rs2o, mem_pcp4  out  XLEN; mem_rdaddr  out  RDW; mem_wbsel  out  WBSELW; mem_memwr, mem_regwr  out  1.
REQ-012 Ports: stall_cnt  out  CNTW  count of back-pressure cycles.

Function
REQ-013 Input transfer SHALL occur on a rising clk edge when ex_valid=1 and ex_ready=1; output transfer when mem_valid=1 and mem_ready=1.
REQ-014 Latency SHALL be exactly one cycle: a bundle accepted at edge N is on mem_* with mem_valid=1 after edge N when the output register is free.
REQ-015 Output register SHALL load only when empty (mem_valid=0) or consumed (mem_ready=1); otherwise all mem_* fields hold.
REQ-016 When output consumed and no new bundle is available, mem_valid SHALL drop to 0 at that edge; data fields hold their last value.
REQ-017 mem_memwr and mem_regwr SHALL read 0 whenever mem_valid=0 (bubble never writes memory or register file).
REQ-018 flush=1 at an edge SHALL clear mem_valid and every buffered entry; flush SHALL take priority over a simultaneous input transfer, which is discarded.
REQ-019 ex_ready SHALL not depend on flush.
REQ-020 stall_cnt SHALL increment by 1 on each edge where mem_valid=1 and mem_ready=0, saturate at 2^CNTW-1, and never wrap.
REQ-021 Bundles SHALL leave in acceptance order; no bundle SHALL be duplicated or dropped except by flush.

Reset
REQ-022 rst_n=0 SHALL immediately, independent of clk, force mem_valid=0, all mem_* data/control=0, stall_cnt=0, skid entry empty.
REQ-023 Reset asserted mid-transfer SHALL discard the in-flight bundle; first accept is allowed on the first edge after rst_n rises.
REQ-024 ex_ready during and immediately after reset SHALL be 1.

Configuration
REQ-025 Macro EX_MEM_SKID_EN SHALL select the ready path.
REQ-026 With EX_MEM_SKID_EN defined: one-entry skid buffer; ex_ready SHALL be a register output equal to "skid empty"; a bundle accepted while the output stalls goes to skid; skid moves to output on the edge mem_ready=1; full throughput with no combinational mem_ready-to-ex_ready path.
REQ-027 Without EX_MEM_SKID_EN: no skid storage; ex_ready SHALL equal (!mem_valid | mem_ready) combinationally.
REQ-028 Both builds SHALL produce identical mem_* sequences for any stimulus where mem_ready never drops.

Verification
REQ-029 Reset then 4 back-to-back bundles ex_alu_res=1..4, mem_ready=1 -> mem_alu_res 1,2,3,4 on consecutive cycles, mem_valid=1 from cycle after first accept, stall_cnt=0.
REQ-030 Bundle A (ex_rdaddr=5, ex_regwr=1) held with mem_ready=0 for 3 cycles -> mem_* stable, stall_cnt=3, no further accept without skid; skid build accepts exactly one more bundle B, then ex_ready=0; releasing mem_ready yields A then B.
REQ-031 flush=1 on same edge as accept of bundle with ex_memwr=1 -> next cycle mem_valid=0, mem_memwr=0; bundle never appears.
REQ-032 stall_cnt with CNTW=4, mem_ready=0 for 20 cycles -> stall_cnt saturates at 15.
REQ-033 rst_n dropped asynchronously between edges while mem_valid=1 -> mem_valid and all outputs 0 before next edge; stall_cnt=0.
REQ-034 Random ex_valid/mem_ready/flush for 10000 cycles in both macro builds -> scoreboard: in-order, no loss or duplication except flushed bundles, mem_regwr=0 whenever mem_valid=0.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake and back-pressure counter.
// Optional one-entry skid buffer selected by macro EX_MEM_SKID_EN: when defined,
// ex_ready is a registered "skid empty" flag and there is no combinational
// mem_ready -> ex_ready path; when undefined, ex_ready = !mem_valid | mem_ready.
module ex_mem_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int RDW    = 5,
  parameter int WBSELW = 2,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_res,
  input  logic [XLEN-1:0]   ex_rs2o,
  input  logic [XLEN-1:0]   ex_pcp4,
  input  logic [RDW-1:0]    ex_rdaddr,
  input  logic [WBSELW-1:0] ex_wbsel,
  input  logic              ex_memwr,
  input  logic              ex_regwr,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_alu_res,
  output logic [XLEN-1:0]   mem_rs2o,
  output logic [XLEN-1:0]   mem_pcp4,
  output logic [RDW-1:0]    mem_rdaddr,
  output logic [WBSELW-1:0] mem_wbsel,
  output logic              mem_memwr,
  output logic              mem_regwr,
  output logic [CNTW-1:0]   stall_cnt
);

  localparam int BW = 3*XLEN + RDW + WBSELW + 2;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [BW-1:0] in_bundle;
  logic [BW-1:0] out_q;
  logic          out_valid_q;
  logic          memwr_q;
  logic          regwr_q;
  logic          out_free;
  logic          in_fire;

  assign in_bundle = {ex_alu_res, ex_rs2o, ex_pcp4, ex_rdaddr, ex_wbsel, ex_memwr, ex_regwr};
  assign {mem_alu_res, mem_rs2o, mem_pcp4, mem_rdaddr, mem_wbsel, memwr_q, regwr_q} = out_q;

  // Write enables are gated by valid so a bubble can never write memory or the register file.
  assign mem_valid = out_valid_q;
  assign mem_memwr = out_valid_q & memwr_q;
  assign mem_regwr = out_valid_q & regwr_q;

  assign out_free = !out_valid_q | mem_ready;
  assign in_fire  = ex_valid & ex_ready;

`ifdef EX_MEM_SKID_EN
  logic          skid_valid_q;
  logic [BW-1:0] skid_q;

  assign ex_ready = !skid_valid_q;

  // Output register fed from skid first (older bundle), else from EX; stalled accepts park in skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_q       <= in_bundle;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q       <= in_bundle;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign ex_ready = out_free;

  // Output register loads whenever it is free; otherwise all fields hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      if (in_fire) begin
        out_q       <= in_bundle;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end
`endif

  // Saturating count of edges where a bundle is present but not consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid_q && !mem_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage (CNTW=4 so saturation is reachable).
// Expectations follow EX_MEM_SKID_EN so the same bench serves both builds.
module tb_ex_mem_pipe_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pcp4;
    logic [4:0]  rd;
    logic [1:0]  wbsel;
    logic        memwr;
    logic        regwr;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_res = '0, ex_rs2o = '0, ex_pcp4 = '0;
  logic [4:0]  ex_rdaddr = '0;
  logic [1:0]  ex_wbsel = '0;
  logic        ex_memwr = 1'b0, ex_regwr = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_alu_res, mem_rs2o, mem_pcp4;
  logic [4:0]  mem_rdaddr;
  logic [1:0]  mem_wbsel;
  logic        mem_memwr, mem_regwr;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  ex_mem_pipe_stage #(.XLEN(32), .RDW(5), .WBSELW(2), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_res(ex_alu_res), .ex_rs2o(ex_rs2o), .ex_pcp4(ex_pcp4),
    .ex_rdaddr(ex_rdaddr), .ex_wbsel(ex_wbsel), .ex_memwr(ex_memwr), .ex_regwr(ex_regwr),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_res(mem_alu_res), .mem_rs2o(mem_rs2o), .mem_pcp4(mem_pcp4),
    .mem_rdaddr(mem_rdaddr), .mem_wbsel(mem_wbsel), .mem_memwr(mem_memwr), .mem_regwr(mem_regwr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bundle_t mk(input logic [31:0] alu, input logic [4:0] rd,
                                 input logic mw, input logic rw);
    bundle_t b;
    b.alu = alu; b.rs2 = ~alu; b.pcp4 = alu + 32'd4;
    b.rd = rd; b.wbsel = alu[1:0]; b.memwr = mw; b.regwr = rw;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.alu = $urandom; b.rs2 = $urandom; b.pcp4 = $urandom;
    b.rd = 5'($urandom); b.wbsel = 2'($urandom);
    b.memwr = 1'($urandom); b.regwr = 1'($urandom);
    return b;
  endfunction

  function automatic bundle_t observed();
    return {mem_alu_res, mem_rs2o, mem_pcp4, mem_rdaddr, mem_wbsel, mem_memwr, mem_regwr};
  endfunction

  task automatic drive(input logic v, input bundle_t b, input logic mr, input logic fl);
    ex_valid = v; ex_alu_res = b.alu; ex_rs2o = b.rs2; ex_pcp4 = b.pcp4;
    ex_rdaddr = b.rd; ex_wbsel = b.wbsel; ex_memwr = b.memwr; ex_regwr = b.regwr;
    mem_ready = mr; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, mk(32'hDEAD, 5'd3, 1'b1, 1'b1), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mem_valid); end
    checks++;
    if (observed() !== '0) begin failures++; $display("FAIL reset_fields got=%h exp=0", observed()); end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    tick();
    checks++;
    if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ex_ready got=%b exp=1", ex_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(32'(i), 5'(i), 1'b0, 1'b1), 1'b1, 1'b0);
      tick();
      checks++;
      if (mem_valid !== 1'b1 || observed() !== mk(32'(i), 5'(i), 1'b0, 1'b1)) begin
        failures++;
        $display("FAIL b2b_%0d got valid=%b alu=%0d exp valid=1 alu=%0d", i, mem_valid, mem_alu_res, i);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_regwr !== 1'b0 || mem_alu_res !== 32'd4) begin
      failures++;
      $display("FAIL b2b_drain got valid=%b regwr=%b alu=%0d exp 0/0/4", mem_valid, mem_regwr, mem_alu_res);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL b2b_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_stall();
    bundle_t a, b;
    logic exp_rdy;
    a = mk(32'd10, 5'd5, 1'b0, 1'b1);
    b = mk(32'd11, 5'd6, 1'b1, 1'b0);
    apply_reset();
    drive(1'b1, a, 1'b0, 1'b0);
    tick();
    drive(1'b1, b, 1'b0, 1'b0);
    #1;
`ifdef EX_MEM_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    checks++;
    if (ex_ready !== exp_rdy) begin failures++; $display("FAIL stall_first_ready got=%b exp=%b", ex_ready, exp_rdy); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (mem_valid !== 1'b1 || observed() !== a || stall_cnt !== 4'(k) || ex_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d got v=%b alu=%0d rd=%0d cnt=%0d rdy=%b exp v=1 alu=10 rd=5 cnt=%0d rdy=0",
                 k, mem_valid, mem_alu_res, mem_rdaddr, stall_cnt, ex_ready, k);
      end
    end
    drive(1'b1, b, 1'b1, 1'b0);
    tick();
    checks++;
    if (mem_valid !== 1'b1 || observed() !== b) begin
      failures++; $display("FAIL stall_release_b got v=%b alu=%0d exp v=1 alu=11", mem_valid, mem_alu_res);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_memwr !== 1'b0) begin
      failures++; $display("FAIL stall_drain got v=%b memwr=%b exp 0/0", mem_valid, mem_memwr);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    drive(1'b1, mk(32'h55, 5'd7, 1'b1, 1'b1), 1'b1, 1'b1);
    tick();
    checks++;
    if (mem_valid !== 1'b0 || mem_memwr !== 1'b0) begin
      failures++; $display("FAIL flush_accept got v=%b memwr=%b exp 0/0", mem_valid, mem_memwr);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("FAIL flush_never_appears got v=%b exp=0", mem_valid); end
    // Fill the stage (and skid, when present) under back-pressure, then flush it all.
    drive(1'b1, mk(32'd20, 5'd1, 1'b1, 1'b0), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(32'd21, 5'd2, 1'b1, 1'b0), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    checks++;
    if (mem_valid !== 1'b0 || ex_ready !== 1'b1 || mem_memwr !== 1'b0) begin
      failures++; $display("FAIL flush_full got v=%b rdy=%b memwr=%b exp 0/1/0", mem_valid, ex_ready, mem_memwr);
    end
    tick();
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("FAIL flush_skid_cleared got v=%b exp=0", mem_valid); end
  endtask

  task automatic test_saturate();
    apply_reset();
    drive(1'b1, mk(32'd30, 5'd9, 1'b0, 1'b1), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (stall_cnt !== 4'((k > 15) ? 15 : k)) begin
        failures++; $display("FAIL sat_%0d got=%0d exp=%0d", k, stall_cnt, (k > 15) ? 15 : k);
      end
    end
  endtask

  task automatic test_async_reset();
    bundle_t c;
    c = mk(32'd40, 5'd12, 1'b1, 1'b1);
    apply_reset();
    drive(1'b1, c, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || observed() !== '0 || stall_cnt !== 4'd0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got v=%b fields=%h cnt=%0d rdy=%b exp 0/0/0/1", mem_valid, observed(), stall_cnt, ex_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, mk(32'd41, 5'd13, 1'b0, 1'b1), 1'b1, 1'b0);
    tick();
    checks++;
    if (mem_valid !== 1'b1 || observed() !== mk(32'd41, 5'd13, 1'b0, 1'b1)) begin
      failures++; $display("FAIL first_accept_after_reset got v=%b alu=%0d exp v=1 alu=41", mem_valid, mem_alu_res);
    end
  endtask

  // Stage modelled as an ordered queue of in-flight bundles with bounded capacity.
  task automatic test_random();
    bundle_t q[$];
    bundle_t b;
    int      cnt;
    logic    v, mr, fl, exp_rdy;
    cnt = 0;
    apply_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      v  = ($urandom_range(0, 9) < 6);
      mr = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 19) == 0);
      b  = rand_bundle();
      drive(v, b, mr, fl);
      #1;
`ifdef EX_MEM_SKID_EN
      exp_rdy = (q.size() < 2);
`else
      exp_rdy = (q.size() == 0) || mr;
`endif
      checks++;
      if (ex_ready !== exp_rdy) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ex_ready, exp_rdy);
      end
      checks++;
      if (mem_valid !== (q.size() > 0)) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, mem_valid, q.size() > 0);
      end
      checks++;
      if (q.size() > 0) begin
        if (observed() !== q[0]) begin
          failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, observed(), q[0]);
        end
      end else if (mem_memwr !== 1'b0 || mem_regwr !== 1'b0) begin
        failures++; $display("FAIL rnd_bubble_wr cyc=%0d got memwr=%b regwr=%b exp 0/0", cyc, mem_memwr, mem_regwr);
      end
      checks++;
      if (stall_cnt !== 4'(cnt)) begin
        failures++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, cnt);
      end
      tick();
      if (q.size() > 0 && !mr && cnt < 15) cnt++;
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && mr) void'(q.pop_front());
        if (v && exp_rdy) q.push_back(b);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
